// File: rtl/alu_cc_unit_pkg.sv
// Shared encodings for the y86 condition-code unit: ALU function codes,
// jXX/cmovXX condition codes and the default datapath width.
package alu_cc_unit_pkg;

  localparam int CC_WIDTH = 64;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3
  } alu_fun_e;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_e;

  // Only the four arithmetic/logic functions may touch the condition codes.
  function automatic logic alu_fun_legal(input logic [3:0] fun);
    return (fun <= 4'd3);
  endfunction

endpackage

// File: rtl/alu_cc_unit_cond_eval.sv
// y86 branch/cmov condition function over held condition codes.
// Purely combinational so the pipelined core can reuse it as-is.
module cond_eval
  import alu_cc_unit_pkg::*;
(
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] cond_fun,
  output logic       cnd
);

  logic lt_s;

  assign lt_s = sf ^ of;

  // Condition table; unused encodings evaluate false.
  always_comb begin
    cnd = 1'b0;
    case (cond_fun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt_s | zf;
      C_L:     cnd = lt_s;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt_s;
      C_G:     cnd = ~lt_s & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cc_unit.sv
// Condition-code register for the sequential y86 core: derives ZF/SF/OF from
// the ALU result, holds them across instructions and evaluates cnd.
module alu_cc_unit
  import alu_cc_unit_pkg::*;
#(
  parameter int WIDTH = CC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             set_cc,
  input  logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic [3:0]       cond_fun,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd,
  output logic             cc_upd,
  output logic             err,
  output logic [15:0]      upd_cnt
);

  logic        zf_q, zf_d;
  logic        sf_q, sf_d;
  logic        of_q, of_d;
  logic        cc_upd_q, cc_upd_d;
  logic        err_q, err_d;
  logic [15:0] upd_cnt_q, upd_cnt_d;

  logic legal_s, upd_s, illegal_s;
  logic sa_s, sb_s, sr_s;
  logic unused_ok_s;

  // Overflow only depends on the operand and result sign bits.
  assign sa_s = alu_a[WIDTH-1];
  assign sb_s = alu_b[WIDTH-1];
  assign sr_s = alu_ans[WIDTH-1];
  assign unused_ok_s = ^{alu_a[WIDTH-2:0], alu_b[WIDTH-2:0]};

  assign legal_s   = alu_fun_legal(alu_fun);
  assign upd_s     = valid & set_cc & legal_s;
  assign illegal_s = valid & set_cc & ~legal_s;

  // Next-state for flags, update pulse, sticky error and update counter.
  always_comb begin
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    cc_upd_d  = 1'b0;
    err_d     = err_q | illegal_s;
    upd_cnt_d = upd_cnt_q;
    if (upd_s) begin
      zf_d      = (alu_ans == {WIDTH{1'b0}});
      sf_d      = sr_s;
      cc_upd_d  = 1'b1;
      upd_cnt_d = upd_cnt_q + 16'd1;
      case (alu_fun)
        ALU_ADD: of_d = (sa_s == sb_s) && (sr_s != sb_s);
        ALU_SUB: of_d = (sa_s != sb_s) && (sr_s != sb_s);
        default: of_d = 1'b0;
      endcase
    end else begin
      cc_upd_d = 1'b0;
    end
  end

  // State registers; ZF resets set so "always/le/e/ge" are true out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      cc_upd_q  <= 1'b0;
      err_q     <= 1'b0;
      upd_cnt_q <= 16'd0;
    end else begin
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      cc_upd_q  <= cc_upd_d;
      err_q     <= err_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  cond_eval u_cond_eval (
    .zf       (zf_q),
    .sf       (sf_q),
    .of       (of_q),
    .cond_fun (cond_fun),
    .cnd      (cnd)
  );

  assign zf      = zf_q;
  assign sf      = sf_q;
  assign of      = of_q;
  assign cc_upd  = cc_upd_q;
  assign err     = err_q;
  assign upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_alu_cc_unit.sv
// Scoreboard bench for alu_cc_unit: expected register state is queued when
// stimulus is driven and compared after the following rising edge.
module tb_alu_cc_unit;
  import alu_cc_unit_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, valid, set_cc;
  logic [3:0]   alu_fun, cond_fun;
  logic [W-1:0] alu_a, alu_b, alu_ans;
  logic         zf, sf, of, cnd, cc_upd, err;
  logic [15:0]  upd_cnt;

  logic         ce_zf, ce_sf, ce_of, ce_cnd;
  logic [3:0]   ce_fun;

  typedef struct packed {
    logic        zf;
    logic        sf;
    logic        of;
    logic        cc_upd;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  alu_cc_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .valid(valid), .set_cc(set_cc),
    .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b), .alu_ans(alu_ans),
    .cond_fun(cond_fun), .zf(zf), .sf(sf), .of(of), .cnd(cnd),
    .cc_upd(cc_upd), .err(err), .upd_cnt(upd_cnt)
  );

  cond_eval u_ce (
    .zf(ce_zf), .sf(ce_sf), .of(ce_of), .cond_fun(ce_fun), .cnd(ce_cnd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic cnd_ref(input logic z, input logic s, input logic o, input logic [3:0] f);
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return (s ^ o) | z;
      4'd2:    return s ^ o;
      4'd3:    return z;
      4'd4:    return ~z;
      4'd5:    return ~(s ^ o);
      4'd6:    return ~(s ^ o) & ~z;
      default: return 1'b0;
    endcase
  endfunction

  // Signed overflow from a 65-bit sign-extended computation.
  function automatic logic add_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] e;
    e = {a[W-1], a} + {b[W-1], b};
    return e[W] != e[W-1];
  endfunction

  function automatic logic sub_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] e;
    e = {b[W-1], b} - {a[W-1], a};
    return e[W] != e[W-1];
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_zf"}, {63'd0, zf}, {63'd0, e.zf});
      check({tag, "_sf"}, {63'd0, sf}, {63'd0, e.sf});
      check({tag, "_of"}, {63'd0, of}, {63'd0, e.of});
      check({tag, "_cc_upd"}, {63'd0, cc_upd}, {63'd0, e.cc_upd});
      check({tag, "_err"}, {63'd0, err}, {63'd0, e.err});
      check({tag, "_cnt"}, {48'd0, upd_cnt}, {48'd0, e.cnt});
    end
  endtask

  // Drive one cycle at the falling edge, queue the expectation, check after the edge.
  task automatic step(input string tag, input logic v, input logic s, input logic [3:0] f,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ans);
    valid = v; set_cc = s; alu_fun = f; alu_a = a; alu_b = b; alu_ans = ans;
    m.cc_upd = 1'b0;
    if (v && s && f <= 4'd3) begin
      m.zf = (ans == 64'd0);
      m.sf = ans[W-1];
      m.of = (f == 4'd0) ? add_ovf(a, b) : (f == 4'd1) ? sub_ovf(a, b) : 1'b0;
      m.cc_upd = 1'b1;
      m.cnt = m.cnt + 16'd1;
    end else if (v && s) begin
      m.err = 1'b1;
    end
    sb_q.push_back(m);
    @(posedge clk);
    @(negedge clk);
    pop_check(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic check_cnd(input logic [3:0] f);
    cond_fun = f;
    idle("cnd_idle");
    check($sformatf("cnd_f%0d_z%0d_s%0d_o%0d", f, m.zf, m.sf, m.of),
          {63'd0, cnd}, {63'd0, cnd_ref(m.zf, m.sf, m.of, f)});
  endtask

  // Reset asserted across an edge while a legal update is presented: reset must win.
  task automatic do_reset(input string tag);
    @(negedge clk);
    valid = 1'b1; set_cc = 1'b1; alu_fun = 4'd0;
    alu_a = 64'd1; alu_b = 64'd2; alu_ans = 64'd3;
    reset = 1'b1;
    m = '{zf: 1'b1, sf: 1'b0, of: 1'b0, cc_upd: 1'b0, err: 1'b0, cnt: 16'd0};
    #1;
    sb_q.push_back(m);
    pop_check({tag, "_async"});
    @(posedge clk);
    @(negedge clk);
    sb_q.push_back(m);
    pop_check({tag, "_held"});
    reset = 1'b0;
    valid = 1'b0; set_cc = 1'b0;
  endtask

  initial begin
    reset = 1'b0; valid = 1'b0; set_cc = 1'b0; alu_fun = 4'd0; cond_fun = 4'd0;
    alu_a = 64'd0; alu_b = 64'd0; alu_ans = 64'd0;
    ce_zf = 1'b0; ce_sf = 1'b0; ce_of = 1'b0; ce_fun = 4'd0;
    m = '0;

    do_reset("rst0");
    check_cnd(4'd3);
    check_cnd(4'd4);
    check_cnd(4'd0);

    step("add_ovf", 1'b1, 1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000);
    check_cnd(4'd2);
    check_cnd(4'd5);

    step("sub_zero", 1'b1, 1'b1, 4'd1, 64'd5, 64'd5, 64'd0);
    check_cnd(4'd1);
    check_cnd(4'd6);

    step("hold_setcc", 1'b1, 1'b0, 4'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    step("hold_valid", 1'b0, 1'b1, 4'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);

    step("sub_ovf", 1'b1, 1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
    step("illegal", 1'b1, 1'b1, 4'd7, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    step("illegal_f", 1'b1, 1'b1, 4'd15, 64'd0, 64'd0, 64'd0);
    step("xor_zero", 1'b1, 1'b1, 4'd3, 64'h1234, 64'h1234, 64'd0);
    step("and_neg", 1'b1, 1'b1, 4'd2, 64'hFFFF_0000_0000_0000, 64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000);
    do_reset("rst_mid");

    // Walk every reachable flag combination through the top and every cond_fun.
    step("c000", 1'b1, 1'b1, 4'd0, 64'd1, 64'd1, 64'd2);
    for (int f = 0; f < 16; f++) check_cnd(4'(f));
    step("c001", 1'b1, 1'b1, 4'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'd2);
    for (int f = 0; f < 16; f++) check_cnd(4'(f));
    step("c010", 1'b1, 1'b1, 4'd3, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    for (int f = 0; f < 16; f++) check_cnd(4'(f));
    step("c011", 1'b1, 1'b1, 4'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000);
    for (int f = 0; f < 16; f++) check_cnd(4'(f));
    step("c100", 1'b1, 1'b1, 4'd2, 64'd0, 64'd7, 64'd0);
    for (int f = 0; f < 16; f++) check_cnd(4'(f));
    step("c101", 1'b1, 1'b1, 4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0);
    for (int f = 0; f < 16; f++) check_cnd(4'(f));

    // The condition evaluator alone, including combinations the ALU cannot produce.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        ce_zf = c[2]; ce_sf = c[1]; ce_of = c[0]; ce_fun = 4'(f);
        #1;
        check($sformatf("ce_f%0d_c%0d", f, c), {63'd0, ce_cnd},
              {63'd0, cnd_ref(c[2], c[1], c[0], 4'(f))});
      end
    end

    do_reset("rst_wrap");
    for (int i = 0; i < 65536; i++) begin
      step("wrap", 1'b1, 1'b1, 4'd0, 64'd1, 64'd1, 64'd2);
    end
    check("wrap_cnt_zero", {48'd0, upd_cnt}, 64'd0);
    idle("wrap_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_cc_unit.md
Name: alu_cc_unit

Overview:
- Consumer end of the 64-bit ALU datapath used by the sequential y86 core.
- Latches the ALU result and its operands, and derives the ZF, SF and OF condition codes from them.
- Holds the codes in a register across instructions.
- Evaluates the y86 branch/cmov condition function against the held codes to produce cnd for the fetch/PC and writeback logic.

Parameters:
- WIDTH, 64, operand and result width in bits. The sign bit is WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- valid  input  1  the ALU result and operands on this cycle belong to an executing instruction.
- set_cc  input  1  the instruction updates the condition codes (OPq class). It is qualified by valid.
- alu_fun  input  4  ALU function: 0 add, 1 sub, 2 and, 3 xor. Values 4..15 are illegal.
- alu_a  input  WIDTH  ALU operand A (valA).
- alu_b  input  WIDTH  ALU operand B (valB).
- alu_ans  input  WIDTH  ALU result. For add it is b+a; for sub it is b-a.
- cond_fun  input  4  condition code field (ifun of jXX/cmovXX).
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered overflow flag.
- cnd  output  1  condition result, computed combinationally from the registered flags and cond_fun.
- cc_upd  output  1  one-cycle pulse: the flags were updated at the preceding edge.
- err  output  1  sticky flag: an illegal alu_fun arrived with valid and set_cc.
- upd_cnt  output  16  count of flag updates since reset.

Behaviour:
- Reset (asynchronous, immediate): zf=1, sf=0, of=0, cc_upd=0, err=0, upd_cnt=0.
  - Because zf resets to 1, cnd is 1 for cond_fun 0, 1, 3 and 5 straight after reset.
- Update condition: valid && set_cc && alu_fun<=3. When true, all three flags load at the rising edge, with a latency of one cycle.
  - zf_next = (alu_ans == 0).
  - sf_next = alu_ans[WIDTH-1].
  - of_next for add: (a[W-1]==b[W-1]) && (ans[W-1]!=b[W-1]).
  - of_next for sub: (a[W-1]!=b[W-1]) && (ans[W-1]!=b[W-1]).
  - of_next for and/xor: 0.
- No update when any of the following holds; the flags keep their value:
  - valid=0;
  - set_cc=0;
  - alu_fun illegal.
- Illegal alu_fun with valid && set_cc:
  - flags hold;
  - err is set at the edge and stays set until reset;
  - cc_upd stays 0.
- cc_upd is registered. It is 1 in the cycle after an update edge and 0 otherwise. Back-to-back updates keep it high continuously.
- upd_cnt increments at each update edge and wraps from 0xFFFF to 0x0000.
- cnd is combinational from the registered flags. An instruction therefore sees the codes set by earlier instructions, not by its own ALU result in the same cycle, which matches SEQ semantics.
  - 0 always: 1.
  - 1 le: (sf^of)|zf.
  - 2 l: sf^of.
  - 3 e: zf.
  - 4 ne: ~zf.
  - 5 ge: ~(sf^of).
  - 6 g: ~(sf^of)&~zf.
  - 7..15: 0, and err is not set.
- If reset is asserted while valid is high, reset wins. The first update can occur at the first rising edge after reset deasserts.
- Inputs are sampled only at rising edges. alu_ans X/glitches between edges do not affect the outputs.

Decomposition:
- Shared package holds:
  - ALU function codes: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_XOR=3.
  - Condition codes: C_YES=0, C_LE=1, C_L=2, C_E=3, C_NE=4, C_GE=5, C_G=6.
  - The WIDTH default.
- One sub-module: cond_eval. It is purely combinational: {zf, sf, of, cond_fun} -> cnd. It is reused by the pipelined core.
- Flag derivation, registers, the counter and the error flag live in the top module.

Test Plan:
- Reset, then check with no stimulus: zf=1, sf=0, of=0, err=0, upd_cnt=0; cond_fun=3 -> cnd=1; cond_fun=4 -> cnd=0.
- Add overflow: valid=1, set_cc=1, fun=0, a=0x7FFF_FFFF_FFFF_FFFF, b=1, ans=0x8000_0000_0000_0000. Next cycle: zf=0, sf=1, of=1, cc_upd=1, upd_cnt=1; cond_fun=2 (l) -> cnd=0; cond_fun=5 (ge) -> cnd=1.
- Sub to zero: fun=1, a=b=5, ans=0. Next cycle: zf=1, sf=0, of=0; cond_fun=1 (le) -> cnd=1; cond_fun=6 (g) -> cnd=0.
- Hold: set_cc=0 with ans=0xFFFF_FFFF_FFFF_FFFE, and separately valid=0 with the same ans. Flags are unchanged from the previous scenario, cc_upd=0, upd_cnt unchanged.
- Illegal fun=7 with valid=1, set_cc=1 -> flags hold and err=1. Then a legal xor with ans=0 -> zf=1, of=0, err still 1. A reset pulse mid-sequence clears everything.
- Counter wrap: 65536 consecutive legal updates -> upd_cnt returns to 0 and cc_upd stays high throughout. Also sweep cond_fun 0..15 against all 8 {zf, sf, of} combinations and check cnd against the table above.
